// File: rtl/sim_run_pkg.sv
// Shared types for the simulation run controller.
//   run_state_t : controller phases (HOLD, RUN, DRAIN, DONE)
//   status_t    : termination cause reported on the status port
package sim_run_pkg;

  localparam int unsigned CNT_W = 64;
  localparam int unsigned TO_W  = 32;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    HALT    = 3'd1,
    TIMEOUT = 3'd2,
    STALL   = 3'd3,
    MON_ERR = 3'd4,
    MEM_ERR = 3'd5
  } status_t;

endpackage

// File: rtl/sim_popcount.sv
// Population count of a CHANNELS-wide vector (purely combinational).
//   vec   : input bit vector
//   count : number of set bits in vec
module sim_popcount #(
  parameter  int unsigned CHANNELS = 8,
  localparam int unsigned CW       = $clog2(CHANNELS + 1)
) (
  input  logic [CHANNELS-1:0] vec,
  output logic [CW-1:0]       count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the DUT in reset, runs it until a halt,
// timeout, stall or error, drains after errors, then reports the cause.
//   clk, rst       : clock and synchronous active-high reset
//   halt, commit   : per-channel halt indication and commit valid
//   mon_error      : monitor error
//   mem_error      : memory model error
//   timeout_cycles : RUN cycle budget, captured on entry to RUN (0 = off)
//   dut_rst        : reset driven to the DUT (high only in HOLD)
//   running        : high only in RUN
//   finish         : one-cycle pulse on entry to DONE
//   status         : termination cause
//   cycle_count    : RUN/DRAIN cycles elapsed (saturating)
//   commit_count   : total commits (saturating)
module sim_run_ctrl
  import sim_run_pkg::*;
#(
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned STALL_LIMIT  = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] halt,
  input  logic [CHANNELS-1:0] commit,
  input  logic                mon_error,
  input  logic                mem_error,
  input  logic [TO_W-1:0]     timeout_cycles,
  output logic                dut_rst,
  output logic                running,
  output logic                finish,
  output logic [2:0]          status,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    commit_count
);

  localparam int unsigned PW = $clog2(CHANNELS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  run_state_t      state;
  status_t         status_q;
  logic [31:0]     hold_cnt;
  logic [31:0]     drain_cnt;
  logic [31:0]     stall_cnt;
  logic [TO_W-1:0] timeout_q;
  logic [PW-1:0]   pop;

  logic [CNT_W-1:0] cycle_inc;
  logic [CNT_W:0]   commit_sum;
  logic [CNT_W-1:0] commit_inc;
  logic [31:0]      stall_inc;
  logic             any_halt;
  logic             any_commit;
  logic             timeout_hit;
  logic             stall_hit;
  logic             hold_last;
  logic             drain_last;

  sim_popcount #(.CHANNELS(CHANNELS)) u_popcount (
    .vec   (commit),
    .count (pop)
  );

  assign status = status_q;

  // Saturating counter updates and termination conditions for this cycle
  always_comb begin
    cycle_inc   = (cycle_count == CNT_MAX) ? CNT_MAX : cycle_count + 64'd1;
    commit_sum  = {1'b0, commit_count} + 65'(pop);
    commit_inc  = commit_sum[CNT_W] ? CNT_MAX : commit_sum[CNT_W-1:0];
    stall_inc   = (stall_cnt == 32'hFFFF_FFFF) ? stall_cnt : stall_cnt + 32'd1;
    any_halt    = |halt;
    any_commit  = |commit;
    // Fires on the cycle whose pre-increment count is budget-1
    timeout_hit = (timeout_q != '0) &&
                  (cycle_count == ({32'd0, timeout_q} - 64'd1));
    // Fires on the idle cycle that brings the stall counter to the limit
    stall_hit   = (STALL_LIMIT != 0) && !any_commit &&
                  (({1'b0, stall_cnt} + 33'd1) >= 33'(STALL_LIMIT));
    hold_last   = ({1'b0, hold_cnt} + 33'd1) >= 33'(RST_CYCLES);
    drain_last  = ({1'b0, drain_cnt} + 33'd1) >= 33'(DRAIN_CYCLES);
  end

  // Run-control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HOLD;
      status_q     <= NONE;
      hold_cnt     <= '0;
      drain_cnt    <= '0;
      stall_cnt    <= '0;
      timeout_q    <= '0;
      cycle_count  <= '0;
      commit_count <= '0;
      dut_rst      <= 1'b1;
      running      <= 1'b0;
      finish       <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        HOLD: begin
          if (hold_last) begin
            state     <= RUN;
            dut_rst   <= 1'b0;
            running   <= 1'b1;
            timeout_q <= timeout_cycles;
          end else begin
            hold_cnt <= hold_cnt + 32'd1;
          end
        end

        RUN: begin
          cycle_count  <= cycle_inc;
          commit_count <= commit_inc;
          stall_cnt    <= any_commit ? '0 : stall_inc;
          // Errors outrank every other cause and go through DRAIN
          if (mon_error || mem_error) begin
            status_q  <= mon_error ? MON_ERR : MEM_ERR;
            running   <= 1'b0;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (any_halt || timeout_hit || stall_hit) begin
            status_q <= any_halt ? HALT : (timeout_hit ? TIMEOUT : STALL);
            running  <= 1'b0;
            state    <= DONE;
            finish   <= 1'b1;
          end
        end

        DRAIN: begin
          cycle_count  <= cycle_inc;
          commit_count <= commit_inc;
          if (drain_last) begin
            state  <= DONE;
            finish <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end

        DONE: begin
          // Absorbing; counters and status frozen until rst
        end

        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule
